// File: rtl/des_ip_loader_if.sv
// Byte-in / permuted-halves-out handshake bundle for the DES IP loader.
// The loader uses the slave view; the producer/consumer side uses master.
interface des_ip_loader_if;
  logic [7:0]  i_Byte;
  logic        i_Valid;
  logic        o_Ready;
  logic        i_Clear;
  logic [31:0] o_L;
  logic [31:0] o_R;
  logic        o_Valid;
  logic        i_Ready;
  logic [2:0]  o_Count;

  modport slave (
    input  i_Byte, i_Valid, i_Clear, i_Ready,
    output o_Ready, o_L, o_R, o_Valid, o_Count
  );

  modport master (
    output i_Byte, i_Valid, i_Clear, i_Ready,
    input  o_Ready, o_L, o_R, o_Valid, o_Count
  );
endinterface

// File: rtl/des_ip_loader.sv
// Collects eight bytes into a DES block, applies the initial permutation and
// holds L0/R0 for the round engine while the next block keeps filling.
module des_ip_loader (
  input  logic           i_Clk,
  input  logic           i_Rst,
  des_ip_loader_if.slave bus
);

  // Only 7 bytes ever need storing; the 8th comes straight from the input.
  logic [55:0] fill_r;
  logic [55:0] fill_nxt_s;
  logic [2:0]  count_r;
  logic [2:0]  count_nxt_s;
  logic [31:0] out_l_r;
  logic [31:0] out_r_r;
  logic [31:0] out_l_nxt_s;
  logic [31:0] out_r_nxt_s;
  logic        out_valid_r;
  logic        out_valid_nxt_s;
  logic        ready_s;
  logic        accept_s;
  logic        xfer_s;
  logic        complete_s;
  logic [63:0] block_s;
  logic [63:0] perm_s;

  // DES IP: output bit 64-p takes input bit 64-IP[p], p = 1 is the MSB.
  function automatic logic [63:0] ip_perm(input logic [63:0] b);
    logic [63:0] o;
    int          r;
    int          c;
    int          ipv;
    logic [5:0]  dst;
    logic [5:0]  src;
    o = 64'd0;
    for (int p = 1; p <= 64; p++) begin
      r = (p - 1) / 8;
      c = (p - 1) % 8;
      if (r < 4) begin
        ipv = 8 * (7 - c) + 2 * r + 2;
      end else begin
        ipv = 8 * (7 - c) + 2 * (r - 4) + 1;
      end
      dst = 6'(64 - p);
      src = 6'(64 - ipv);
      o[dst] = b[src];
    end
    return o;
  endfunction

  // Handshake qualifiers and the permuted candidate block.
  always_comb begin
    ready_s    = !((count_r == 3'd7) && out_valid_r && !bus.i_Ready);
    accept_s   = bus.i_Valid && ready_s;
    xfer_s     = out_valid_r && bus.i_Ready;
    // A clear in the same cycle suppresses the completing byte.
    complete_s = accept_s && (count_r == 3'd7) && !bus.i_Clear;
    block_s    = {fill_r, bus.i_Byte};
    perm_s     = ip_perm(block_s);
  end

  // Next-state for the fill side and the output holding register.
  always_comb begin
    fill_nxt_s      = fill_r;
    count_nxt_s     = count_r;
    out_l_nxt_s     = out_l_r;
    out_r_nxt_s     = out_r_r;
    out_valid_nxt_s = out_valid_r;

    if (bus.i_Clear) begin
      fill_nxt_s  = 56'd0;
      count_nxt_s = 3'd0;
    end else if (accept_s) begin
      fill_nxt_s  = {fill_r[47:0], bus.i_Byte};
      count_nxt_s = count_r + 3'd1;
    end else begin
      fill_nxt_s  = fill_r;
      count_nxt_s = count_r;
    end

    if (complete_s) begin
      out_l_nxt_s     = perm_s[63:32];
      out_r_nxt_s     = perm_s[31:0];
      out_valid_nxt_s = 1'b1;
    end else if (xfer_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      fill_r      <= 56'd0;
      count_r     <= 3'd0;
      out_l_r     <= 32'd0;
      out_r_r     <= 32'd0;
      out_valid_r <= 1'b0;
    end else begin
      fill_r      <= fill_nxt_s;
      count_r     <= count_nxt_s;
      out_l_r     <= out_l_nxt_s;
      out_r_r     <= out_r_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign bus.o_Ready = ready_s;
  assign bus.o_L     = out_l_r;
  assign bus.o_R     = out_r_r;
  assign bus.o_Valid = out_valid_r;
  assign bus.o_Count = count_r;

endmodule
